// File: rtl/fp_add_align.sv
// Two-stage operand alignment front end for a floating-point adder feeding a 64-bit CLA.
// Define FP_ALIGN_SUBNORM_EN for gradual underflow; otherwise exp==0 operands flush to signed zero.
module fp_add_align #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [EXP_W+MAN_W:0]   i_a,
  input  logic [EXP_W+MAN_W:0]   i_b,
  input  logic                   i_op_sub,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [63:0]            o_man_a,
  output logic [63:0]            o_man_b,
  output logic                   o_c_in,
  output logic                   o_sub,
  output logic [EXP_W-1:0]       o_exp,
  output logic                   o_sign,
  output logic                   o_nan,
  output logic                   o_inf
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int MW  = MAN_W + 4;
  localparam int PAD = 64 - MW;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] diff;
    logic [MW-1:0]    man_a;
    logic [MW-1:0]    man_b;
    logic             sign;
    logic             sub;
    logic             nan;
    logic             inf;
  } s1_t;

  typedef struct packed {
    logic [63:0]      man_a;
    logic [63:0]      man_b;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             sub;
    logic             nan;
    logic             inf;
  } s2_t;

  function automatic logic [MW-1:0] build_man(input logic [EXP_W-1:0] e,
                                              input logic [MAN_W-1:0] f);
`ifdef FP_ALIGN_SUBNORM_EN
    return {(e != '0), f, 3'b000};
`else
    return (e == '0) ? '0 : {1'b1, f, 3'b000};
`endif
  endfunction

  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
`ifdef FP_ALIGN_SUBNORM_EN
    return (e == '0) ? EXP_W'(1) : e;
`else
    return e;
`endif
  endfunction

  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  logic s2_free, s1_advance, s1_load;

  // Handshake: a stage moves when it is empty or its successor moves.
  always_comb begin
    s2_free    = !s2_valid_q || i_ready;
    s1_advance = s1_valid_q && s2_free;
    o_ready    = !s1_valid_q || s1_advance;
    s1_load    = i_valid && o_ready;
    s1_valid_d = o_ready ? i_valid : s1_valid_q;
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
  end

  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b, eexp_a, eexp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [MW-1:0]    man_a, man_b;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             a_ge_b, mag_eq, sub_eff;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sign_a = i_a[W-1];
    sign_b = i_b[W-1];
    exp_a  = i_a[W-2 -: EXP_W];
    exp_b  = i_b[W-2 -: EXP_W];
    frac_a = i_a[MAN_W-1:0];
    frac_b = i_b[MAN_W-1:0];
    nan_a  = (exp_a == '1) && (frac_a != '0);
    nan_b  = (exp_b == '1) && (frac_b != '0);
    inf_a  = (exp_a == '1) && (frac_a == '0);
    inf_b  = (exp_b == '1) && (frac_b == '0);
    man_a  = build_man(exp_a, frac_a);
    man_b  = build_man(exp_b, frac_b);
    eexp_a = eff_exp(exp_a);
    eexp_b = eff_exp(exp_b);
    a_ge_b  = {eexp_a, man_a} >= {eexp_b, man_b};
    mag_eq  = {eexp_a, man_a} == {eexp_b, man_b};
    sub_eff = sign_a ^ sign_b ^ i_op_sub;

    s1_d = s1_q;
    if (s1_load) begin
      s1_d.sub = sub_eff;
      s1_d.nan = nan_a || nan_b || (inf_a && inf_b && sub_eff);
      s1_d.inf = (inf_a || inf_b) && !s1_d.nan;
      if (a_ge_b) begin
        s1_d.exp   = eexp_a;
        s1_d.diff  = eexp_a - eexp_b;
        s1_d.man_a = man_a;
        s1_d.man_b = man_b;
        s1_d.sign  = (mag_eq && sub_eff) ? 1'b0 : sign_a;
      end else begin
        s1_d.exp   = eexp_b;
        s1_d.diff  = eexp_b - eexp_a;
        s1_d.man_a = man_b;
        s1_d.man_b = man_a;
        s1_d.sign  = sign_b ^ i_op_sub;
      end
    end
  end

  logic [31:0] diff_ext;
  logic [63:0] man_b_ext, shifted, lost;
  logic        sticky;

  // Bits shifted past S collapse into S; huge distances leave only S.
  always_comb begin
    diff_ext  = 32'(s1_q.diff);
    man_b_ext = {{PAD{1'b0}}, s1_q.man_b};
    shifted   = '0;
    lost      = '0;
    sticky    = 1'b0;
    if (diff_ext >= 32'(MW)) begin
      sticky = |s1_q.man_b;
    end else begin
      shifted = man_b_ext >> diff_ext[5:0];
      lost    = man_b_ext & ((64'd1 << diff_ext[5:0]) - 64'd1);
      sticky  = |lost;
    end
    shifted[0] = shifted[0] | sticky;

    s2_d = s2_q;
    if (s1_advance) begin
      s2_d.man_a = {{PAD{1'b0}}, s1_q.man_a};
      s2_d.man_b = s1_q.sub ? ~shifted : shifted;
      s2_d.exp   = s1_q.exp;
      s2_d.sign  = s1_q.sign;
      s2_d.sub   = s1_q.sub;
      s2_d.nan   = s1_q.nan;
      s2_d.inf   = s1_q.inf;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign o_valid = s2_valid_q;
  assign o_man_a = s2_q.man_a;
  assign o_man_b = s2_q.man_b;
  assign o_exp   = s2_q.exp;
  assign o_sign  = s2_q.sign;
  assign o_sub   = s2_q.sub;
  assign o_c_in  = s2_q.sub;
  assign o_nan   = s2_q.nan;
  assign o_inf   = s2_q.inf;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed self-checking bench for fp_add_align (double precision defaults).
module tb_fp_add_align;

  localparam logic [63:0] ONE     = 64'h3FF0000000000000;
  localparam logic [63:0] NONE    = 64'hBFF0000000000000;
  localparam logic [63:0] HALF    = 64'h3FE0000000000000;
  localparam logic [63:0] TWO     = 64'h4000000000000000;
  localparam logic [63:0] NTWO    = 64'hC000000000000000;
  localparam logic [63:0] SIXTEEN = 64'h4030000000000000;
  localparam logic [63:0] ONE_ULP = 64'h3FF0000000000001;
  localparam logic [63:0] TINY    = 64'h39B0000000000000;
  localparam logic [63:0] QNAN    = 64'h7FF8000000000000;
  localparam logic [63:0] INF     = 64'h7FF0000000000000;
  localparam logic [63:0] SUBN    = 64'h0000000000000001;
  localparam logic [63:0] HID     = 64'h0080000000000000;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [63:0] i_a = '0;
  logic [63:0] i_b = '0;
  logic        i_op_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [63:0] o_man_a, o_man_b;
  logic        o_c_in, o_sub, o_sign, o_nan, o_inf;
  logic [10:0] o_exp;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_align dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op_sub(i_op_sub), .o_valid(o_valid), .i_ready(i_ready),
    .o_man_a(o_man_a), .o_man_b(o_man_b), .o_c_in(o_c_in), .o_sub(o_sub),
    .o_exp(o_exp), .o_sign(o_sign), .o_nan(o_nan), .o_inf(o_inf)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Drives one pair, checks the two-cycle latency, returns with the result on the outputs.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic op);
    @(negedge i_clk);
    i_a = a; i_b = b; i_op_sub = op; i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("latency1_valid", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    check("latency2_valid", 64'(o_valid), 64'd1);
  endtask

  function automatic logic [63:0] mk(input logic [10:0] e);
    return {1'b0, e, 52'd0};
  endfunction

  initial begin
    #12;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_man_a", o_man_a, 64'd0);
    check("rst_exp", 64'(o_exp), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    issue(ONE, ONE, 1'b0);
    check("add_eq_exp", 64'(o_exp), 64'h3FF);
    check("add_eq_man_a", o_man_a, HID);
    check("add_eq_man_b", o_man_b, HID);
    check("add_eq_sub", 64'(o_sub), 64'd0);
    check("add_eq_cin", 64'(o_c_in), 64'd0);
    check("add_eq_flags", {62'd0, o_nan, o_inf}, 64'd0);

    issue(ONE, HALF, 1'b0);
    check("half_man_b", o_man_b, 64'h0040000000000000);
    check("half_exp", 64'(o_exp), 64'h3FF);
    issue(HALF, ONE, 1'b0);
    check("half_sw_man_a", o_man_a, HID);
    check("half_sw_man_b", o_man_b, 64'h0040000000000000);
    check("half_sw_exp", 64'(o_exp), 64'h3FF);
    check("half_sw_sign", 64'(o_sign), 64'd0);

    issue(ONE, ONE, 1'b1);
    check("sub_eq_sub", 64'(o_sub), 64'd1);
    check("sub_eq_cin", 64'(o_c_in), 64'd1);
    check("sub_eq_man_b", o_man_b, 64'hFF7FFFFFFFFFFFFF);
    check("sub_eq_sign", 64'(o_sign), 64'd0);
    issue(NONE, NONE, 1'b1);
    check("nsub_eq_sign", 64'(o_sign), 64'd0);

    issue(ONE, TINY, 1'b0);
    check("far_man_b", o_man_b, 64'h1);

    issue(SIXTEEN, ONE_ULP, 1'b0);
    check("sticky_man_b", o_man_b, 64'h0008000000000001);
    check("sticky_exp", 64'(o_exp), 64'h403);

    issue(ONE, NTWO, 1'b0);
    check("mix_sub", 64'(o_sub), 64'd1);
    check("mix_sign", 64'(o_sign), 64'd1);
    check("mix_exp", 64'(o_exp), 64'h400);
    check("mix_man_a", o_man_a, HID);
    check("mix_man_b", o_man_b, 64'hFFBFFFFFFFFFFFFF);
    issue(ONE, TWO, 1'b1);
    check("sub_swap_sign", 64'(o_sign), 64'd1);

    issue(QNAN, ONE, 1'b0);
    check("nan_flags", {62'd0, o_nan, o_inf}, 64'd2);
    issue(INF, INF, 1'b1);
    check("inf_inf_flags", {62'd0, o_nan, o_inf}, 64'd2);
    issue(INF, ONE, 1'b0);
    check("inf_flags", {62'd0, o_nan, o_inf}, 64'd1);
    check("inf_exp", 64'(o_exp), 64'h7FF);

    issue(ONE, SUBN, 1'b0);
`ifdef FP_ALIGN_SUBNORM_EN
    check("subn_man_b", o_man_b, 64'h1);
`else
    check("subn_man_b", o_man_b, 64'h0);
`endif
    issue(SUBN, 64'd0, 1'b0);
`ifdef FP_ALIGN_SUBNORM_EN
    check("subn_man_a", o_man_a, 64'h8);
    check("subn_exp", 64'(o_exp), 64'h1);
`else
    check("subn_man_a", o_man_a, 64'h0);
    check("subn_exp", 64'(o_exp), 64'h0);
`endif

    // Backpressure: four pairs with distinct exponents, downstream stalled three cycles.
    @(negedge i_clk);
    i_ready = 1'b0;
    check("bp_ready0", 64'(o_ready), 64'd1);
    i_a = mk(11'h3F0); i_b = mk(11'h3F0); i_op_sub = 1'b0; i_valid = 1'b1;
    @(negedge i_clk);
    check("bp_ready1", 64'(o_ready), 64'd1);
    i_a = mk(11'h3F1); i_b = mk(11'h3F1);
    @(negedge i_clk);
    check("bp_valid_p0", 64'(o_valid), 64'd1);
    check("bp_exp_p0", 64'(o_exp), 64'h3F0);
    check("bp_ready_full", 64'(o_ready), 64'd0);
    i_a = mk(11'h3F2); i_b = mk(11'h3F2);
    @(negedge i_clk);
    check("bp_ready_held", 64'(o_ready), 64'd0);
    check("bp_exp_stable", 64'(o_exp), 64'h3F0);
    check("bp_man_stable", o_man_a, HID);
    i_ready = 1'b1;
    @(negedge i_clk);
    check("bp_exp_p1", 64'(o_exp), 64'h3F1);
    check("bp_ready_resume", 64'(o_ready), 64'd1);
    i_a = mk(11'h3F3); i_b = mk(11'h3F3);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("bp_exp_p2", 64'(o_exp), 64'h3F2);
    @(negedge i_clk);
    check("bp_valid_p3", 64'(o_valid), 64'd1);
    check("bp_exp_p3", 64'(o_exp), 64'h3F3);
    @(negedge i_clk);
    check("bp_drained", 64'(o_valid), 64'd0);

    // Reset with two pairs in flight.
    i_a = ONE; i_b = ONE; i_valid = 1'b1;
    @(negedge i_clk);
    i_a = TWO; i_b = TWO;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("inflight_valid", 64'(o_valid), 64'd1);
    #1 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_ready", 64'(o_ready), 64'd1);
    check("mid_rst_man_a", o_man_a, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("post_rst_no_stale", 64'(o_valid), 64'd0);
    end
    issue(ONE, HALF, 1'b0);
    check("post_rst_exp", 64'(o_exp), 64'h3FF);
    check("post_rst_man_b", o_man_b, 64'h0040000000000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
